// File: rtl/ucsbece154b_bpred_gshare_assoc_pkg.sv
// Shared definitions for the gshare predictor with set-associative BTB:
// update-type encodings, RISC-V control-flow opcodes and width helpers.
package ucsbece154b_bpred_gshare_assoc_pkg;

  typedef enum logic [1:0] {
    UPD_OTHER  = 2'b00,
    UPD_BRANCH = 2'b01,
    UPD_JAL    = 2'b10,
    UPD_JALR   = 2'b11
  } upd_type_e;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  // Lets decode stages classify an instruction for the update port.
  function automatic logic [1:0] opcodeToType(input logic [6:0] opcode);
    logic [1:0] kind;
    kind = UPD_OTHER;
    if (opcode == OPCODE_BRANCH) kind = UPD_BRANCH;
    else if (opcode == OPCODE_JAL) kind = UPD_JAL;
    else if (opcode == OPCODE_JALR) kind = UPD_JALR;
    return kind;
  endfunction

  // Index width that stays legal (at least one bit) for a count of one.
  function automatic int idxBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ucsbece154b_btb_assoc.sv
// Set-associative branch target buffer with per-set age-counter LRU.
// One combinational lookup port for fetch and one write port for execute.
module ucsbece154b_btb_assoc
  import ucsbece154b_bpred_gshare_assoc_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:2] lookup_pc_i,
  output logic        lookup_hit_o,
  output logic [1:0]  lookup_type_o,
  output logic [31:0] lookup_target_o,
  input  logic        upd_en_i,
  input  logic [31:2] upd_pc_i,
  input  logic [1:0]  upd_type_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int SB    = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - SB;
  localparam int WW    = idxBits(NUM_WAYS);

  logic             valid_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q    [NUM_SETS][NUM_WAYS];
  logic [31:0]      target_q [NUM_SETS][NUM_WAYS];
  logic [1:0]       type_q   [NUM_SETS][NUM_WAYS];

  logic [SB-1:0]    lkSet, upSet;
  logic [TAG_W-1:0] lkTag, upTag;
  logic [WW-1:0]    lkWay, upWay, freeWay, lruWay, victimWay, wrWay;
  logic             upHit, freeFound, doWrite;

  assign lkSet = lookup_pc_i[SB+1:2];
  assign lkTag = lookup_pc_i[31:SB+2];
  assign upSet = upd_pc_i[SB+1:2];
  assign upTag = upd_pc_i[31:SB+2];

  always_comb begin
    lookup_hit_o = 1'b0;
    lkWay = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lkSet][w] && tag_q[lkSet][w] == lkTag) begin
        lookup_hit_o = 1'b1;
        lkWay = WW'(w);
      end
    end
  end

  assign lookup_type_o   = type_q[lkSet][lkWay];
  assign lookup_target_o = target_q[lkSet][lkWay];

  // Descending scan so the lowest-index free way wins.
  always_comb begin
    upHit = 1'b0;
    upWay = '0;
    freeFound = 1'b0;
    freeWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[upSet][w] && tag_q[upSet][w] == upTag) begin
        upHit = 1'b1;
        upWay = WW'(w);
      end
      if (!valid_q[upSet][w]) begin
        freeFound = 1'b1;
        freeWay = WW'(w);
      end
    end
  end

  assign victimWay = freeFound ? freeWay : lruWay;
  assign wrWay     = upHit ? upWay : victimWay;
  assign doWrite   = upd_en_i & (upHit | upd_taken_i);

  // A not-taken hit refreshes only the type; the target is kept.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          valid_q[s][w] <= 1'b0;
    end else if (doWrite) begin
      valid_q[upSet][wrWay] <= 1'b1;
      tag_q[upSet][wrWay]   <= upTag;
      type_q[upSet][wrWay]  <= upd_type_i;
      if (upd_taken_i) target_q[upSet][wrWay] <= upd_target_i;
    end
  end

  if (NUM_WAYS > 1) begin : gLru
    localparam int AW = $clog2(NUM_WAYS);
    logic [AW-1:0] age_q [NUM_SETS][NUM_WAYS];
    logic [AW-1:0] touchedAge;

    assign touchedAge = age_q[upSet][wrWay];

    always_comb begin
      lruWay = '0;
      for (int w = 0; w < NUM_WAYS; w++)
        if (age_q[upSet][w] == AW'(NUM_WAYS - 1)) lruWay = WW'(w);
    end

    // Ages form a permutation per set; the oldest way is the victim.
    always_ff @(posedge clk) begin
      if (reset_i) begin
        for (int s = 0; s < NUM_SETS; s++)
          for (int w = 0; w < NUM_WAYS; w++)
            age_q[s][w] <= AW'(NUM_WAYS - 1 - w);
      end else if (doWrite) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WW'(w) == wrWay) age_q[upSet][w] <= '0;
          else if (age_q[upSet][w] < touchedAge) age_q[upSet][w] <= age_q[upSet][w] + AW'(1);
        end
      end
    end
  end else begin : gNoLru
    assign lruWay = '0;
  end

endmodule

// File: rtl/ucsbece154b_bpred_gshare_assoc.sv
// Fetch-stage predictor: associative BTB plus gshare PHT with a speculative,
// checkpointed global history that execute repairs on a mispredict.
module ucsbece154b_bpred_gshare_assoc
  import ucsbece154b_bpred_gshare_assoc_pkg::*;
#(
  parameter int NUM_BTB_SETS = 8,
  parameter int NUM_BTB_WAYS = 2,
  parameter int NUM_GHR_BITS = 5,
  parameter int CTR_BITS     = 2
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [31:0]             pc_i,
  input  logic                    fetch_valid_i,
  output logic                    predtaken_o,
  output logic [31:0]             predtarget_o,
  output logic [NUM_GHR_BITS-1:0] predghr_o,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [1:0]              upd_type_i,
  input  logic                    upd_taken_i,
  input  logic [31:0]             upd_target_i,
  input  logic [NUM_GHR_BITS-1:0] upd_ghr_i,
  input  logic                    upd_mispredict_i
);

  localparam int PHT_DEPTH = 1 << NUM_GHR_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

  logic [CTR_BITS-1:0]     pht_q [PHT_DEPTH];
  logic [NUM_GHR_BITS-1:0] ghr_q, ghr_d;
  logic [NUM_GHR_BITS-1:0] rdIdx, wrIdx;
  logic [CTR_BITS-1:0]     wrCtr, wrCtrNext;
  logic                    btbHit, predTaken, updBranch;
  logic [1:0]              btbType;
  logic [31:0]             btbTarget;
  logic [1:0]              unusedPcBits;

  assign unusedPcBits = upd_pc_i[1:0];

  ucsbece154b_btb_assoc #(
    .NUM_SETS(NUM_BTB_SETS),
    .NUM_WAYS(NUM_BTB_WAYS)
  ) btb (
    .clk            (clk),
    .reset_i        (reset_i),
    .lookup_pc_i    (pc_i[31:2]),
    .lookup_hit_o   (btbHit),
    .lookup_type_o  (btbType),
    .lookup_target_o(btbTarget),
    .upd_en_i       (upd_valid_i && upd_type_i != UPD_OTHER),
    .upd_pc_i       (upd_pc_i[31:2]),
    .upd_type_i     (upd_type_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i)
  );

  assign rdIdx     = pc_i[NUM_GHR_BITS+1:2] ^ ghr_q;
  assign wrIdx     = upd_pc_i[NUM_GHR_BITS+1:2] ^ upd_ghr_i;
  assign updBranch = upd_valid_i && upd_type_i == UPD_BRANCH;

  always_comb begin
    predTaken = 1'b0;
    if (btbHit) begin
      if (btbType == UPD_JAL || btbType == UPD_JALR) predTaken = 1'b1;
      else if (btbType == UPD_BRANCH) predTaken = pht_q[rdIdx][CTR_BITS-1];
    end
  end

  // Outputs are forced to the sequential-fetch default while reset is held.
  assign predtaken_o  = predTaken & ~reset_i;
  assign predtarget_o = predtaken_o ? btbTarget : pc_i + 32'd4;
  assign predghr_o    = reset_i ? '0 : ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i && upd_mispredict_i)
      ghr_d = (upd_type_i == UPD_BRANCH) ? {upd_ghr_i[NUM_GHR_BITS-2:0], upd_taken_i} : upd_ghr_i;
    else if (fetch_valid_i && btbHit && btbType == UPD_BRANCH)
      ghr_d = {ghr_q[NUM_GHR_BITS-2:0], predTaken};
  end

  always_ff @(posedge clk) begin
    if (reset_i) ghr_q <= '0;
    else ghr_q <= ghr_d;
  end

  always_comb begin
    wrCtr = pht_q[wrIdx];
    wrCtrNext = wrCtr;
    if (upd_taken_i && wrCtr != CTR_MAX) wrCtrNext = wrCtr + CTR_ONE;
    else if (!upd_taken_i && wrCtr != '0) wrCtrNext = wrCtr - CTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CTR_INIT;
    end else if (updBranch) begin
      pht_q[wrIdx] <= wrCtrNext;
    end
  end

endmodule
